// File: rtl/btn_event_pkg.sv
// Shared types and default timing for the button event generator.
// No logic; constants only.
// Default values assume a 100 MHz core clock.
package btn_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    // 0.5 s hold and 0.1 s repeat interval at 100 MHz
    localparam int DEF_HOLD_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;
    localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/btn_event_if.sv
// Button level in, event pulses / status out.
// master = event generator, slave = consumer (pattern FSM / display).
// No handshake: pulses are fire-and-forget, one cycle wide.
interface btn_event_if;
    logic       btn_in;
    logic       press_pulse;
    logic       release_pulse;
    logic       hold_pulse;
    logic       repeat_pulse;
    logic       pressed;
    logic [7:0] press_count;

    modport master (
        input  btn_in,
        output press_pulse, release_pulse, hold_pulse, repeat_pulse,
        output pressed, press_count
    );

    modport slave (
        output btn_in,
        input  press_pulse, release_pulse, hold_pulse, repeat_pulse,
        input  pressed, press_count
    );
endinterface

// File: rtl/btn_interval_counter.sv
// Interval counter with sync clear, enable and terminal-count compare.
// tc is combinational in the cycle cnt==tc_val while enabled; counter wraps to 0 there.
// No backpressure; clear dominates enable.
module btn_interval_counter #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Terminal count only counts while enabled so a frozen counter never fires
    assign tc = en && (cnt == tc_val);

    // Count up, restart from 0 on terminal count so cnt never exceeds tc_val
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/btn_event_gen.sv
// Debounced button level -> press/release/hold/(repeat) pulses, press counter.
// All outputs registered, 1 cycle after the sampling edge. Optional: BTN_EVENT_REPEAT_EN.
// No backpressure; pulses are single-cycle and at most one is high per cycle.
module btn_event_gen
    import btn_event_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    btn_event_if.master  ev
);

    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_t       state;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_limit;

    logic       press_q;
    logic       release_q;
    logic       hold_q;
    logic       pressed_q;
    logic [7:0] count_q;

    // Hold interval until the hold event, repeat interval afterwards
    assign cnt_limit = (state == ST_HELD) ? REPEAT_TC : HOLD_TC;

    // Counter runs only while the button stays down in a timed state;
    // a release or idle state parks it at zero
    always_comb begin
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;
        case (state)
            ST_PRESSED: begin
                if (ev.btn_in) begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                end
            end
            ST_HELD: begin
`ifdef BTN_EVENT_REPEAT_EN
                if (ev.btn_in) begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    btn_interval_counter #(
        .CNT_W (CNT_W)
    ) u_interval (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc_val (cnt_limit),
        .tc     (cnt_tc)
    );

`ifdef BTN_EVENT_REPEAT_EN
    logic repeat_q;
`endif

    // Event FSM; release is tested first so it wins over hold/repeat on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
            pressed_q <= 1'b0;
            count_q   <= 8'd0;
`ifdef BTN_EVENT_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (ev.btn_in) begin
                        state     <= ST_PRESSED;
                        press_q   <= 1'b1;
                        pressed_q <= 1'b1;
                        count_q   <= count_q + 8'd1;
                    end
                end
                ST_PRESSED: begin
                    if (!ev.btn_in) begin
                        state     <= ST_IDLE;
                        release_q <= 1'b1;
                        pressed_q <= 1'b0;
                    end else if (cnt_tc) begin
                        state  <= ST_HELD;
                        hold_q <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!ev.btn_in) begin
                        state     <= ST_IDLE;
                        release_q <= 1'b1;
                        pressed_q <= 1'b0;
                    end
`ifdef BTN_EVENT_REPEAT_EN
                    else if (cnt_tc) begin
                        repeat_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    state     <= ST_IDLE;
                    pressed_q <= 1'b0;
                end
            endcase
        end
    end

    assign ev.press_pulse   = press_q;
    assign ev.release_pulse = release_q;
    assign ev.hold_pulse    = hold_q;
    assign ev.pressed       = pressed_q;
    assign ev.press_count   = count_q;
`ifdef BTN_EVENT_REPEAT_EN
    assign ev.repeat_pulse  = repeat_q;
`else
    assign ev.repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with HOLD=8, REPEAT=3, CNT_W=4.
// Times are counted in cycles after the first edge that samples btn_in=1.
// Repeat expectations follow BTN_EVENT_REPEAT_EN.
module tb_btn_event_gen;

    localparam int HOLD = 8;
    localparam int REP  = 3;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic reset;

    btn_event_if ifc ();

    btn_event_gen #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .CNT_W         (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ev    (ifc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int press_t, rel_t, hold_t, rep_n, pressed_n, press_n;
    int multi_n = 0;
    int rep_t[8];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs_word();
        return int'({ifc.press_pulse, ifc.release_pulse, ifc.hold_pulse,
                     ifc.repeat_pulse, ifc.pressed, ifc.press_count});
    endfunction

    // Hold btn_in high for n sampling edges, observe for total cycles
    task automatic run_press(input int n, input int total);
        int k;
        press_t = -1; rel_t = -1; hold_t = -1;
        rep_n = 0; pressed_n = 0; press_n = 0;
        ifc.btn_in = 1'b1;
        for (k = 1; k <= total; k++) begin
            tick();
            if (k == n) ifc.btn_in = 1'b0;
            if (ifc.press_pulse) begin
                press_n++;
                if (press_t < 0) press_t = k;
            end
            if (ifc.release_pulse && rel_t < 0)  rel_t = k;
            if (ifc.hold_pulse && hold_t < 0)    hold_t = k;
            if (ifc.repeat_pulse) begin
                if (rep_n < 8) rep_t[rep_n] = k;
                rep_n++;
            end
            if (ifc.pressed) pressed_n++;
            if (int'(ifc.press_pulse) + int'(ifc.release_pulse) +
                int'(ifc.hold_pulse) + int'(ifc.repeat_pulse) > 1) multi_n++;
        end
    endtask

    int exp_cnt;

    initial begin
        // Reset held 3 cycles with the button already down
        reset = 1'b1;
        ifc.btn_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outputs", outs_word(), 0);
        end
        reset = 1'b0;
        tick();
        chk("post_reset_press", int'(ifc.press_pulse), 1);
        chk("post_reset_count", int'(ifc.press_count), 1);
        chk("post_reset_pressed", int'(ifc.pressed), 1);
        ifc.btn_in = 1'b0;
        tick();
        chk("post_reset_release", int'(ifc.release_pulse), 1);
        tick();
        exp_cnt = 1;

        // Short press: 4 cycles
        run_press(4, 8);
        exp_cnt++;
        chk("short_press_t", press_t, 1);
        chk("short_release_t", rel_t, 5);
        chk("short_no_hold", hold_t, -1);
        chk("short_pressed_len", pressed_n, 4);
        chk("short_count", int'(ifc.press_count), exp_cnt);

        // Long press: 20 cycles, hold then repeats
        run_press(20, 24);
        exp_cnt++;
        chk("long_press_t", press_t, 1);
        chk("long_hold_t", hold_t, 9);
        chk("long_release_t", rel_t, 21);
        chk("long_pressed_len", pressed_n, 20);
`ifdef BTN_EVENT_REPEAT_EN
        chk("long_repeat_n", rep_n, 3);
        chk("long_repeat0_t", rep_t[0], 12);
        chk("long_repeat1_t", rep_t[1], 15);
        chk("long_repeat2_t", rep_t[2], 18);
`else
        chk("long_repeat_n", rep_n, 0);
`endif
        chk("long_count", int'(ifc.press_count), exp_cnt);

        // Release on the edge where the hold compare would fire
        run_press(8, 12);
        exp_cnt++;
        chk("edge_release_t", rel_t, 9);
        chk("edge_no_hold", hold_t, -1);
        chk("edge_no_repeat", rep_n, 0);

        // One more cycle makes it a hold
        run_press(9, 12);
        exp_cnt++;
        chk("edge_hold_t", hold_t, 9);
        chk("edge_hold_release_t", rel_t, 10);

        // Single-cycle press
        run_press(1, 4);
        exp_cnt++;
        chk("one_cyc_press_t", press_t, 1);
        chk("one_cyc_release_t", rel_t, 2);
        chk("one_cyc_press_n", press_n, 1);
        chk("one_cyc_count", int'(ifc.press_count), exp_cnt);

        // Reset mid-hold with the button still down
        ifc.btn_in = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("mid_pressed", int'(ifc.pressed), 1);
        reset = 1'b1;
        tick();
        chk("mid_reset_outputs", outs_word(), 0);
        reset = 1'b0;
        tick();
        chk("mid_reset_press", int'(ifc.press_pulse), 1);
        chk("mid_reset_count", int'(ifc.press_count), 1);
        ifc.btn_in = 1'b0;
        tick();
        tick();

        // Counter wrap: 256 presses of 2 high / 2 low from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("wrap_start", int'(ifc.press_count), 0);
        for (int i = 1; i <= 256; i++) begin
            ifc.btn_in = 1'b1;
            tick();
            tick();
            ifc.btn_in = 1'b0;
            tick();
            tick();
            if (i == 128) chk("wrap_128", int'(ifc.press_count), 128);
            if (i == 255) chk("wrap_255", int'(ifc.press_count), 255);
            if (i == 256) chk("wrap_256", int'(ifc.press_count), 0);
        end

        chk("one_pulse_max", multi_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
